// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: credit-limited fetch into a DEPTH-entry FIFO, with redirect flush of stale responses.
// Optional performance counters are enabled by defining PREFETCH_PERF_EN.
module inst_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        FETCH,
        FLUSH
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   drop_count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            credit;
    logic            req_acc;
    logic            push;
    logic            pop;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   redir_drop;
    logic [31:0]     rsp_pc;
    logic            unused_pc_lsb;

    // Low address bits of a redirect target are forced to a word boundary.
    assign unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_nxt     = state;
        credit        = ({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(DEPTH);
        mem_req_valid = rst && (state == FETCH) && credit;
        req_acc       = mem_req_valid && mem_req_ready;
        push          = (state == FETCH) && mem_rsp_valid && !redirect;
        pop           = inst_valid && inst_ready && !redirect;
        // Requests still owed a response: live ones in FETCH, stale ones in FLUSH.
        in_flight     = (state == FETCH) ? outstanding : drop_count;
        redir_drop    = in_flight - CW'(mem_rsp_valid) + CW'(req_acc);
        // Responses return in order, so the oldest outstanding request sits outstanding*4 behind fetch_pc.
        rsp_pc        = fetch_pc - (32'(outstanding) << 2);

        if (redirect) begin
            state_nxt = (redir_drop != '0) ? FLUSH : FETCH;
        end else if (state == FLUSH) begin
            if ((drop_count == '0) || ((drop_count == CW'(1)) && mem_rsp_valid)) begin
                state_nxt = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            occupancy   <= '0;
            drop_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                outstanding <= '0;
                occupancy   <= '0;
                drop_count  <= redir_drop;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (req_acc) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (state == FETCH) begin
                    outstanding <= outstanding + CW'(req_acc) - CW'(mem_rsp_valid);
                end else if (mem_rsp_valid && (drop_count != '0)) begin
                    drop_count <= drop_count - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                occupancy <= occupancy + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= mem_rsp_data;
        end
    end

    assign inst_valid = (occupancy != '0);
    assign mem_addr   = fetch_pc;
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr] : '0;
    assign inst_pc4   = inst_valid ? (pc_mem[rd_ptr] + 32'd4) : '0;

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushes <= perf_flushes + 32'(redirect);
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit: in-order memory model plus instruction scoreboard, directed scenarios.
module tb_inst_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    always #5 clk = ~clk;

    inst_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_pc4      (inst_pc4)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushes  (perf_flushes)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ep;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] epoch     = 0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          rsp_en;
    int          pop_cnt   = 0;
    int          stale_cnt = 0;
    bit          cap_en    = 0;
    int          cap_n     = 0;
    logic [31:0] cap_pc  [3];
    logic [31:0] cap_pc4 [3];
    logic        s_rv, s_iv, s_rsp;
    logic [31:0] s_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Memory returns ~addr as the instruction word, in order, never in the accept cycle.
    task automatic drive_mem();
        if (rst && rsp_en && pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ~pend[0].addr;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    task automatic monitor();
        bit    stale;
        pend_t e;
        s_rv   = mem_req_valid;
        s_addr = mem_addr;
        s_iv   = inst_valid;
        s_rsp  = mem_rsp_valid;
        if (!rst) begin
            pend.delete();
            exp_q.delete();
            exp_fetch = RESET_PC;
            return;
        end
        stale = 1'b0;
        foreach (pend[i]) if (pend[i].ep != epoch) stale = 1'b1;
        chk("req_valid", {31'b0, mem_req_valid},
            {31'b0, (!stale && (pend.size() + exp_q.size() < DEPTH))});
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, (exp_q.size() != 0)});
        if (inst_valid && exp_q.size() > 0) begin
            chk("inst_pc", inst_pc, exp_q[0]);
            chk("inst_data", inst_data, ~exp_q[0]);
            chk("inst_pc4", inst_pc4, exp_q[0] + 32'd4);
            if (inst_ready && !redirect) begin
                void'(exp_q.pop_front());
                pop_cnt++;
                if (cap_en && cap_n < 3) begin
                    cap_pc[cap_n]  = inst_pc;
                    cap_pc4[cap_n] = inst_pc4;
                    cap_n++;
                end
            end
        end
        if (mem_rsp_valid && pend.size() > 0) begin
            e = pend.pop_front();
            if (e.ep != epoch) stale_cnt++;
            else if (!redirect) exp_q.push_back(e.addr);
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("mem_addr", mem_addr, exp_fetch);
            pend.push_back('{addr: mem_addr, ep: epoch});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect) begin
            exp_q.delete();
            epoch     = epoch + 1;
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic cyc();
        drive_mem();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic wait_caps(input int n, input string tag);
        for (int i = 0; i < 60 && cap_n < n; i++) cyc();
        chk(tag, 32'(cap_n), 32'(n));
    endtask

    initial begin
        int first_v;
        int pc0;
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (3) cyc();
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_pc4", inst_pc4, 32'd0);

        // Streaming start-up and steady state
        rst = 1'b1;
        first_v = -1; cap_en = 1'b1; cap_n = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (c == 0) begin
                chk("first_req_valid", {31'b0, s_rv}, 32'd1);
                chk("first_req_addr", s_addr, RESET_PC);
            end
            if (s_iv && first_v < 0) first_v = c;
        end
        chk("startup_latency", 32'(first_v), 32'd2);
        chk("stream_pops", 32'(pop_cnt), 32'd18);
        chk("stream_pc0", cap_pc[0], 32'h0);
        chk("stream_pc1", cap_pc[1], 32'h4);
        chk("stream_pc2", cap_pc[2], 32'h8);

        // Backpressure
        inst_ready = 1'b0;
        repeat (10) cyc();
        chk("bp_req_valid", {31'b0, s_rv}, 32'd0);
        chk("bp_inflight", 32'(pend.size() + exp_q.size()), 32'(DEPTH));
        inst_ready = 1'b1;
        pc0 = pop_cnt;
        repeat (20) cyc();
        chk("bp_release_pops", {31'b0, (pop_cnt - pc0 >= 12)}, 32'd1);

        // Redirect with three requests in flight
        mem_req_ready = 1'b0;
        repeat (8) cyc();
        chk("drained", {31'b0, s_iv}, 32'd0);
        rsp_en = 1'b0; mem_req_ready = 1'b1;
        repeat (3) cyc();
        mem_req_ready = 1'b0;
        chk("pre_redirect_outstanding", 32'(pend.size()), 32'd3);
        stale_cnt = 0; cap_n = 0;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cyc();
        rsp_en = 1'b1; mem_req_ready = 1'b1;
        cyc();
        chk("flush_no_req", {31'b0, s_rv}, 32'd0);
        wait_caps(1, "redir100_delivered");
        chk("flush_dropped", 32'(stale_cnt), 32'd3);
        chk("redir100_pc", cap_pc[0], 32'h0000_0100);

        // Redirect coinciding with a response and a pop, unaligned target
        repeat (6) cyc();
        cap_n = 0;
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        cyc();
        chk("coinc_rsp", {31'b0, s_rsp}, 32'd1);
        chk("coinc_pop", {31'b0, s_iv}, 32'd1);
        cyc();
        chk("coinc_fifo_empty", {31'b0, s_iv}, 32'd0);
        wait_caps(1, "redir200_delivered");
        chk("redir200_pc", cap_pc[0], 32'h0000_0200);

        // Address wrap
        repeat (4) cyc();
        cap_n = 0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        wait_caps(3, "wrap_delivered");
        chk("wrap_pc0", cap_pc[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", cap_pc[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", cap_pc[2], 32'h0000_0000);
        chk("wrap_pc4_1", cap_pc4[1], 32'h0000_0000);

        // Reset mid-stream with two outstanding and a non-empty FIFO
        mem_req_ready = 1'b0;
        repeat (8) cyc();
        rsp_en = 1'b0; inst_ready = 1'b0; mem_req_ready = 1'b1;
        repeat (5) cyc();
        mem_req_ready = 1'b0; rsp_en = 1'b1;
        repeat (2) cyc();
        rsp_en = 1'b0;
        cyc();
        chk("pre_rst_outstanding", 32'(pend.size()), 32'd2);
        chk("pre_rst_inst_valid", {31'b0, s_iv}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_rst_inst_data", inst_data, 32'd0);
        chk("mid_rst_inst_pc", inst_pc, 32'd0);
        chk("mid_rst_inst_pc4", inst_pc4, 32'd0);
`ifdef PREFETCH_PERF_EN
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_flushes_rst", perf_flushes, 32'd0);
`endif
        mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        cap_n = 0;
        cyc();
        chk("post_rst_req_valid", {31'b0, s_rv}, 32'd1);
        chk("post_rst_addr", s_addr, RESET_PC);
        wait_caps(1, "post_rst_delivered");
        chk("post_rst_pc", cap_pc[0], RESET_PC);
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_prefetch_unit.md
INST_PREFETCH_UNIT -- requirements
Module: inst_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries and maximum outstanding requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 redirect  input  1  pipeline redirect (taken branch or jump); one-cycle pulse.
REQ-006 redirect_pc  input  32  new fetch address; bits[1:0] ignored and treated as 0.
REQ-007 mem_req_valid  output  1  fetch request to instruction memory.
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_addr  output  32  word-aligned fetch address; stable while mem_req_valid=1 and mem_req_ready=0.
REQ-010 mem_rsp_valid  input  1  response beat; responses arrive in request order, one per accepted request, never in the acceptance cycle.
REQ-011 mem_rsp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  FIFO head is valid.
REQ-013 inst_ready  input  1  core consumes the head (driven by ~stall).
REQ-014 inst_data / inst_pc / inst_pc4  output  32 each  head instruction, its PC, and PC+4 (mod 2^32).

Function
REQ-015 FSM states: FETCH, FLUSH. Reset enters FETCH.
REQ-016 FETCH: mem_req_valid=1 iff (outstanding + occupancy) < DEPTH; a request is accepted when mem_req_valid and mem_req_ready are both 1.
REQ-017 On acceptance, fetch_pc advances by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0) and outstanding increments.
REQ-018 In FETCH, mem_rsp_valid pushes {fetch-order PC, data} into the FIFO and decrements outstanding; the credit rule guarantees no overflow.
REQ-019 A pop occurs when inst_valid and inst_ready are both 1; push and pop in the same cycle leave occupancy unchanged.
REQ-020 inst_* outputs are driven from registered FIFO storage, not combinationally from mem_rsp_*; minimum response-to-inst_valid latency is 1 cycle.
REQ-021 Redirect (either state): FIFO is cleared and any pop that cycle is discarded; fetch_pc <= {redirect_pc[31:2],2'b00}; drop_count <= outstanding, less 1 if a response arrives that cycle, plus 1 if a request is accepted that cycle.
REQ-022 After a redirect, the next state is FLUSH if the resulting drop_count > 0, else FETCH.
REQ-023 FLUSH: mem_req_valid=0; each response is discarded and decrements drop_count; the FSM moves to FETCH in the cycle after drop_count reaches 0.
REQ-024 Redirect while already in FLUSH restarts the flush with the new address; REQ-021 accounting applies.
REQ-025 The flush bound is DEPTH stale responses; no stale instruction ever appears on inst_valid.
REQ-026 inst_valid=0 whenever the FIFO is empty; no speculative bypass.

Reset
REQ-027 While rst=0: state=FETCH, fetch_pc=RESET_PC, occupancy=outstanding=drop_count=0, mem_req_valid=0, inst_valid=0, inst_data=inst_pc=inst_pc4=0.
REQ-028 Reset mid-operation discards all in-flight requests; the memory is reset by the same rst.
REQ-029 mem_req_valid=1 in the first cycle after rst deasserts, with mem_addr=RESET_PC.

Configuration
REQ-030 Macro PREFETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (FIFO pushes) and perf_flushes[31:0] (redirects); both reset to 0 and wrap at 2^32.
REQ-031 Macro PREFETCH_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Verification
REQ-032 Streaming: zero-wait memory, inst_ready=1 -> PCs 0,4,8,... one per cycle after a 2-cycle start-up; inst_pc4 = inst_pc+4.
REQ-033 Backpressure: inst_ready=0 for 10 cycles -> occupancy+outstanding capped at 4; mem_req_valid=0 once capped; no loss or duplication on release.
REQ-034 Redirect to 0x100 with 3 outstanding -> exactly 3 responses dropped in FLUSH; next inst_pc=0x100.
REQ-035 Redirect with redirect_pc=0x203 coinciding with a response and a pop -> FIFO empty next cycle; first delivered inst_pc=0x200.
REQ-036 fetch_pc=0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; inst_pc4 of 0xFFFF_FFFC = 0.
REQ-037 rst pulsed low mid-stream with 2 outstanding -> all outputs 0 immediately; after release the first mem_addr=RESET_PC; PREFETCH_PERF_EN counters read 0.
